// File: rtl/input_acc_sched_pkg.sv
// Shared types and widths for the input accumulator scheduler.
package input_acc_sched_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/input_acc_row_cnt.sv
// Per-row fill counter: saturates at DEPTH, cleared after a drain.
module input_acc_row_cnt #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full_c
);

  assign full_c = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !full_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_acc_sched.sv
// Fills per-row input accumulators from host/nn writes, then drains them
// with a one-cycle-per-row skew for the systolic array.
module input_acc_sched
  import input_acc_sched_pkg::*;
#(
  parameter  int unsigned NUM_ROWS = 2,
  parameter  int unsigned DEPTH    = 4,
  localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic signed [DATA_W-1:0] host_data,
  input  logic [ROW_W-1:0]         host_row,
  input  logic                     nn_valid,
  output logic                     nn_ready,
  input  logic signed [DATA_W-1:0] nn_data,
  input  logic [ROW_W-1:0]         nn_row,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_ROWS-1:0]      acc_valid_data_in,
  output logic [NUM_ROWS-1:0]      acc_valid_data_nn_in,
  output logic [NUM_ROWS-1:0]      acc_valid_in,
  output logic signed [DATA_W-1:0] acc_data_in,
  output logic signed [DATA_W-1:0] acc_data_nn_in
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned C_W   = $clog2(NUM_ROWS + DEPTH + 1);

  state_t              state_q, state_d;
  logic [C_W-1:0]      c_q, c_d, c_sel, drain_end;
  logic                busy_d, done_d, clr;
  logic [NUM_ROWS-1:0] mask, av_d, full, inc;
  logic [CNT_W-1:0]    count [NUM_ROWS];
  logic                accept_ok, nn_fire, host_fire;

  // Writes only while filling, never alongside start; nn wins over host.
  assign accept_ok  = rst_n && !start && (state_q == IDLE || state_q == FILL);
  assign nn_ready   = accept_ok && (32'(nn_row) < NUM_ROWS) && !full[nn_row];
  assign host_ready = accept_ok && !nn_valid && (32'(host_row) < NUM_ROWS) && !full[host_row];
  assign nn_fire    = nn_valid && nn_ready;
  assign host_fire  = host_valid && host_ready;
  assign clr        = (state_q == DONE);

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign inc[r] = (nn_fire && nn_row == ROW_W'(r)) || (host_fire && host_row == ROW_W'(r));

    input_acc_row_cnt #(.DEPTH(DEPTH)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc[r]),
      .clr    (clr),
      .count  (count[r]),
      .full_c (full[r])
    );
  end

  // Counts are frozen during DRAIN (no writes accepted), so they act as the snapshot.
  always_comb begin
    drain_end = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (count[r] != '0 && (C_W'(r) + C_W'(count[r])) > drain_end) begin
        drain_end = C_W'(r) + C_W'(count[r]);
      end
    end
  end

  // Drain cycle whose pattern is loaded at the coming edge.
  assign c_sel = (state_q == DRAIN) ? c_q + C_W'(1) : '0;

  always_comb begin
    mask = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      mask[r] = (c_sel >= C_W'(r)) && (c_sel < C_W'(r) + C_W'(count[r]));
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    busy_d  = busy;
    done_d  = 1'b0;
    av_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (nn_fire || host_fire) state_d = FILL;
      end
      FILL: begin
        if (start) begin
          state_d = DRAIN;
          c_d     = '0;
          busy_d  = 1'b1;
          av_d    = mask;
        end
      end
      DRAIN: begin
        if (c_q == drain_end - C_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          c_d  = c_q + C_W'(1);
          av_d = mask;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        c_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      c_q                  <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      acc_valid_in         <= '0;
      acc_valid_data_in    <= '0;
      acc_valid_data_nn_in <= '0;
      acc_data_in          <= '0;
      acc_data_nn_in       <= '0;
    end else begin
      state_q              <= state_d;
      c_q                  <= c_d;
      busy                 <= busy_d;
      done                 <= done_d;
      acc_valid_in         <= av_d;
      acc_valid_data_nn_in <= nn_fire ? (NUM_ROWS'(1) << nn_row) : '0;
      acc_valid_data_in    <= host_fire ? (NUM_ROWS'(1) << host_row) : '0;
      if (nn_fire)   acc_data_nn_in <= nn_data;
      if (host_fire) acc_data_in    <= host_data;
    end
  end

endmodule

// File: tb/tb_input_acc_sched.sv
// Scoreboard bench for input_acc_sched: directed cases plus random traffic.
module tb_input_acc_sched;

  localparam int NR = 2;
  localparam int DP = 4;
  localparam int S_IDLE = 0, S_FILL = 1, S_DRAIN = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_valid, nn_valid, start;
  logic signed [15:0] host_data, nn_data;
  logic [0:0] host_row, nn_row;
  logic host_ready, nn_ready, busy, done;
  logic [NR-1:0] avd, avnn, avin;
  logic signed [15:0] adi, adnn;

  always #5 clk = ~clk;

  input_acc_sched #(.NUM_ROWS(NR), .DEPTH(DP)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .host_valid           (host_valid),
    .host_ready           (host_ready),
    .host_data            (host_data),
    .host_row             (host_row),
    .nn_valid             (nn_valid),
    .nn_ready             (nn_ready),
    .nn_data              (nn_data),
    .nn_row               (nn_row),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .acc_valid_data_in    (avd),
    .acc_valid_data_nn_in (avnn),
    .acc_valid_in         (avin),
    .acc_data_in          (adi),
    .acc_data_nn_in       (adnn)
  );

  typedef struct packed {
    logic        nn;
    logic [0:0]  row;
    logic [15:0] data;
  } wr_t;

  wr_t           wr_q[$];
  logic [NR-1:0] drain_q[$];
  int tests = 0;
  int fails = 0;
  int m_cnt[NR];
  int m_st = S_IDLE;
  int m_k  = 0;

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic flag(string name, int got);
    tests++;
    fails++;
    $display("FAIL %s got=%0d (nothing expected) t=%0t", name, got, $time);
  endtask

  // Monitor: pops expected write strobes and drain patterns as the DUT shows them.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n) begin
      if ((avd | avnn) != '0) begin
        if (wr_q.size() == 0) begin
          flag("unexpected_strobe", int'(avd | avnn));
        end else begin
          e = wr_q.pop_front();
          check("nn_strobe", int'(avnn), e.nn ? (1 << e.row) : 0);
          check("host_strobe", int'(avd), e.nn ? 0 : (1 << e.row));
          check(e.nn ? "nn_data" : "host_data",
                int'(e.nn ? $unsigned(adnn) : $unsigned(adi)), int'(e.data));
        end
      end
      if (busy && !done) begin
        if (drain_q.size() == 0) flag("unexpected_drain_cycle", int'(avin));
        else check("acc_valid_in", int'(avin), int'(drain_q.pop_front()));
      end else begin
        if (avin != '0) check("acc_valid_in_outside_drain", int'(avin), 0);
        if (done) check("drain_cycles_left_at_done", drain_q.size(), 0);
      end
    end
  end

  // One stimulus cycle: drive after the edge, check handshake/status, advance the model.
  task automatic cyc(bit nv, logic [15:0] nd, logic [0:0] nr,
                     bit hv, logic [15:0] hd, logic [0:0] hr, bit st);
    bit en_nn, en_h, alive;
    int end_c;
    logic [NR-1:0] m;
    wr_t w;
    @(posedge clk);
    #1;
    nn_valid = nv; nn_data = nd; nn_row = nr;
    host_valid = hv; host_data = hd; host_row = hr;
    start = st;
    @(negedge clk);
    alive = (m_st == S_IDLE || m_st == S_FILL) && !st;
    en_nn = alive && m_cnt[nr] < DP;
    en_h  = alive && !nv && m_cnt[hr] < DP;
    check("nn_ready", int'(nn_ready), int'(en_nn));
    check("host_ready", int'(host_ready), int'(en_h));
    check("busy", int'(busy), int'(m_st == S_DRAIN || m_st == S_DONE));
    check("done", int'(done), int'(m_st == S_DONE));
    case (m_st)
      S_IDLE, S_FILL: begin
        if (nv && en_nn) begin
          m_cnt[nr]++;
          w.nn = 1'b1; w.row = nr; w.data = nd;
          wr_q.push_back(w);
          m_st = S_FILL;
        end else if (hv && en_h) begin
          m_cnt[hr]++;
          w.nn = 1'b0; w.row = hr; w.data = hd;
          wr_q.push_back(w);
          m_st = S_FILL;
        end else if (st && m_st == S_FILL) begin
          end_c = 0;
          for (int r = 0; r < NR; r++)
            if (m_cnt[r] > 0 && r + m_cnt[r] > end_c) end_c = r + m_cnt[r];
          for (int c = 0; c < end_c; c++) begin
            m = '0;
            for (int r = 0; r < NR; r++) m[r] = (c >= r) && (c < r + m_cnt[r]);
            drain_q.push_back(m);
          end
          m_st = S_DRAIN;
          m_k  = end_c;
        end
      end
      S_DRAIN: begin
        m_k--;
        if (m_k == 0) m_st = S_DONE;
      end
      default: begin
        m_st  = S_IDLE;
        m_cnt = '{default: 0};
      end
    endcase
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic hw(logic [15:0] d, logic [0:0] r);
    cyc(1'b0, 16'd0, 1'b0, 1'b1, d, r, 1'b0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_host_ready"}, int'(host_ready), 0);
    check({tag, "_nn_ready"}, int'(nn_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_strobes"}, int'({avd, avnn, avin}), 0);
    check({tag, "_data"}, int'({$unsigned(adi), $unsigned(adnn)}), 0);
  endtask

  task automatic flush_model();
    wr_q.delete();
    drain_q.delete();
    m_st  = S_IDLE;
    m_k   = 0;
    m_cnt = '{default: 0};
  endtask

  initial begin
    m_cnt = '{default: 0};
    host_valid = 1'b1; nn_valid = 1'b1; start = 1'b0;
    host_data = 16'sd1; nn_data = 16'sd2; host_row = 1'b0; nn_row = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    host_valid = 1'b0; nn_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Host writes 5,6 to row 0; then nn/host collision.
    hw(16'd5, 1'b0);
    hw(16'd6, 1'b0);
    cyc(1'b1, 16'd7, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
    // Row 0 to full; host and nn both refused there, row 1 still open.
    hw(16'd9, 1'b0);
    hw(16'd10, 1'b0);
    hw(16'd11, 1'b0);
    cyc(1'b1, 16'd12, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    hw(16'd13, 1'b1);
    // Start with a concurrent nn write: write refused, drain begins.
    cyc(1'b1, 16'd14, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(8);
    // Start in IDLE is ignored.
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(2);
    // Counts {2,3} then drain.
    hw(16'hfff0, 1'b0); hw(16'd21, 1'b0);
    hw(16'd30, 1'b1); hw(16'h8000, 1'b1); hw(16'd32, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(7);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(bit'($urandom_range(0, 9) < 3), 16'($urandom), 1'($urandom_range(0, 1)),
          bit'($urandom_range(0, 9) < 5), 16'($urandom), 1'($urandom_range(0, 1)),
          bit'($urandom_range(0, 15) == 0));
    end
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(12);

    // Reset at c=1 of a drain aborts it with no done pulse.
    hw(16'd40, 1'b0); hw(16'd41, 1'b0);
    hw(16'd42, 1'b1); hw(16'd43, 1'b1); hw(16'd44, 1'b1);
    cyc(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
    idle(1);
    @(posedge clk);
    #1;
    check("pre_abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    flush_model();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    hw(16'd50, 1'b1);
    idle(2);

    check("wr_q_left", wr_q.size(), 0);
    check("drain_q_left", drain_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
